// File: rtl/axi_wr_arbiter_pkg.sv
// Shared types for the AXI write-channel arbiter: payload structs, FSM states and sizing.
package axi_arb_pkg;

   localparam int unsigned ID_W      = 4;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned STRB_W    = DATA_W / 8;
   localparam int unsigned NUM_M_MAX = 4;
   localparam int unsigned IDX_W     = $clog2(NUM_M_MAX);

   typedef struct packed {
      logic [ID_W-1:0]   awid;
      logic [ADDR_W-1:0] awaddr;
      logic [3:0]        awlen;
      logic [2:0]        awsize;
      logic [1:0]        awburst;
   } aw_t;

   typedef struct packed {
      logic [ID_W-1:0]   wid;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
      logic              wlast;
   } w_t;

   typedef struct packed {
      logic [ID_W-1:0] bid;
      logic [1:0]      bresp;
   } b_t;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} arb_state_t;

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_M_MAX-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_M_MAX; i++) begin
         if (oh[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: first requester at or after the pointer wins (one-hot).
module axi_rr_picker
   import axi_arb_pkg::*;
#(
   parameter int unsigned NUM_M = 2
) (
   input  logic [IDX_W-1:0] i_ptr,
   input  logic [NUM_M-1:0] i_req,
   output logic [NUM_M-1:0] o_grant
);

   logic w_found;

   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      for (int unsigned k = 0; k < NUM_M; k++) begin
         for (int unsigned j = 0; j < NUM_M; j++) begin
            if (!w_found && i_req[j] && (j == (32'(i_ptr) + k) % NUM_M)) begin
               o_grant[j] = 1'b1;
               w_found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/axi_wr_arbiter.sv
// NUM_M-master AXI write arbiter; one master owns AW/W/B for a whole transaction.
// Optional `AXI_WR_ARB_LEN_CHECK_EN: beat counter drives wlast and flags length mismatches on err.
module axi_wr_arbiter
   import axi_arb_pkg::*;
#(
   parameter int unsigned NUM_M = 2
) (
   input  logic             aclk,
   input  logic             arst,
   input  logic [NUM_M-1:0] m_awvalid,
   output logic [NUM_M-1:0] m_awready,
   input  aw_t  [NUM_M-1:0] m_aw,
   input  logic [NUM_M-1:0] m_wvalid,
   output logic [NUM_M-1:0] m_wready,
   input  w_t   [NUM_M-1:0] m_w,
   output logic [NUM_M-1:0] m_bvalid,
   input  logic [NUM_M-1:0] m_bready,
   output b_t               m_b,
   output logic             s_awvalid,
   input  logic             s_awready,
   output aw_t              s_aw,
   output logic             s_wvalid,
   input  logic             s_wready,
   output w_t               s_w,
   input  logic             s_bvalid,
   output logic             s_bready,
   input  b_t               s_b,
   output logic [NUM_M-1:0] grant,
   output logic             err
);

   arb_state_t           r_state;
   arb_state_t           w_state_nxt;
   logic [IDX_W-1:0]     r_ptr;
   logic [IDX_W-1:0]     r_owner;
   logic [NUM_M-1:0]     r_grant;
   logic [NUM_M-1:0]     w_pick;
   logic [NUM_M_MAX-1:0] w_pick_ext;
   aw_t                  w_own_aw;
   w_t                   w_own_w;
   logic                 w_last_beat;
   logic                 w_b_hs;

   axi_rr_picker #(.NUM_M(NUM_M)) u_picker (
      .i_ptr   (r_ptr),
      .i_req   (m_awvalid),
      .o_grant (w_pick)
   );

   always_comb begin
      w_pick_ext             = '0;
      w_pick_ext[NUM_M-1:0]  = w_pick;
   end

   // Owner payload mux; r_grant is one-hot (or zero in IDLE).
   always_comb begin
      w_own_aw = '0;
      w_own_w  = '0;
      for (int unsigned i = 0; i < NUM_M; i++) begin
         if (r_grant[i]) begin
            w_own_aw = m_aw[i];
            w_own_w  = m_w[i];
         end
      end
   end

   assign s_aw   = w_own_aw;
   assign m_b    = s_b;
   assign grant  = r_grant;
   assign w_b_hs = s_bvalid & s_bready;

`ifdef AXI_WR_ARB_LEN_CHECK_EN
   logic [3:0] r_beats;
   logic       w_cnt_last;
   logic       w_aw_hs;
   logic       w_w_hs;

   assign w_aw_hs     = s_awvalid & s_awready;
   assign w_w_hs      = s_wvalid & s_wready;
   assign w_cnt_last  = (r_beats == 4'd0);
   assign w_last_beat = w_cnt_last;
   assign err         = (r_state == DATA) & w_w_hs & (w_own_w.wlast != w_cnt_last);

   always_comb begin
      s_w       = w_own_w;
      s_w.wlast = w_cnt_last;
   end

   always_ff @(posedge aclk) begin
      if (arst) begin
         r_beats <= '0;
      end else if (w_aw_hs) begin
         r_beats <= w_own_aw.awlen;
      end else if (w_w_hs) begin
         r_beats <= r_beats - 4'd1;
      end
   end
`else
   assign w_last_beat = w_own_w.wlast;
   assign err         = 1'b0;
   assign s_w         = w_own_w;
`endif

   always_ff @(posedge aclk) begin
      if (arst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      s_awvalid   = 1'b0;
      s_wvalid    = 1'b0;
      s_bready    = 1'b0;
      m_awready   = '0;
      m_wready    = '0;
      m_bvalid    = '0;
      unique case (r_state)
         IDLE: begin
            if (|m_awvalid) w_state_nxt = ADDR;
         end
         ADDR: begin
            s_awvalid = |(m_awvalid & r_grant);
            m_awready = r_grant & {NUM_M{s_awready}};
            if (s_awvalid & s_awready) w_state_nxt = DATA;
         end
         DATA: begin
            s_wvalid = |(m_wvalid & r_grant);
            m_wready = r_grant & {NUM_M{s_wready}};
            if (s_wvalid & s_wready & w_last_beat) w_state_nxt = RESP;
         end
         RESP: begin
            m_bvalid = r_grant & {NUM_M{s_bvalid}};
            s_bready = |(m_bready & r_grant);
            if (s_bvalid & s_bready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Owner is captured when leaving IDLE; pointer advances past it once B completes.
   always_ff @(posedge aclk) begin
      if (arst) begin
         r_ptr   <= '0;
         r_owner <= '0;
         r_grant <= '0;
      end else if (r_state == IDLE && |m_awvalid) begin
         r_grant <= w_pick;
         r_owner <= onehot_to_idx(w_pick_ext);
      end else if (r_state == RESP && w_b_hs) begin
         r_grant <= '0;
         r_ptr   <= (r_owner == IDX_W'(NUM_M - 1)) ? '0 : r_owner + 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter (two masters, bench acts as masters and slave).
module tb_axi_wr_arbiter;
   import axi_arb_pkg::*;

   localparam int unsigned NUM_M = 2;

   logic             aclk;
   logic             arst;
   logic [NUM_M-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready, grant;
   aw_t  [NUM_M-1:0] m_aw;
   w_t   [NUM_M-1:0] m_w;
   b_t               m_b, s_b;
   aw_t              s_aw;
   w_t               s_w;
   logic             s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready, err;

   int checks   = 0;
   int failures = 0;

   axi_wr_arbiter #(.NUM_M(NUM_M)) dut (
      .aclk(aclk), .arst(arst),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b),
      .grant(grant), .err(err)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic clear_inputs();
      m_awvalid = '0; m_wvalid = '0; m_bready = '0;
      m_aw = '0; m_w = '0; s_b = '0;
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      arst = 1'b1;
      @(negedge aclk);
      arst = 1'b0;
   endtask

   // Stimulus driver: slave accepts the AW, both masters offer identical W beats, slave returns B.
   task automatic serve(input logic [3:0] len, input int stall_beat, input logic [31:0] d0,
                        output logic [NUM_M-1:0] g, output int wc, output int beats,
                        output int bad, output int leak, output logic [NUM_M-1:0] bv,
                        output aw_t aw);
      g = '0; wc = 0; beats = 0; bad = 0; leak = 0; bv = '0; aw = '0;
      s_awready = 1'b1;
      #1;
      while (s_awvalid !== 1'b1 && wc < 8) begin
         @(negedge aclk); #1; wc++;
      end
      if (s_awvalid !== 1'b1) begin
         wc = -1; s_awready = 1'b0;
         return;
      end
      g = grant; aw = s_aw;
      @(negedge aclk);
      m_awvalid = m_awvalid & ~g;
      s_awready = 1'b0;
      m_wvalid  = '1;
      s_wready  = 1'b1;
      for (int b = 0; b <= int'(len); b++) begin
         for (int i = 0; i < NUM_M; i++) begin
            m_w[i].wid   = 4'h1;
            m_w[i].wdata = d0 + 32'(b);
            m_w[i].wstrb = '1;
            m_w[i].wlast = (b == int'(len));
         end
         if (b == stall_beat) begin
            s_wready = 1'b0;
            repeat (3) begin
               #1;
               if (m_wready !== '0 || s_wvalid !== 1'b1) bad++;
               @(negedge aclk);
            end
            s_wready = 1'b1;
         end
         #1;
         if (s_awvalid !== 1'b0) leak++;
         if (err !== 1'b0) bad++;
         if (s_wvalid === 1'b1 && m_wready === g) begin
            beats++;
            if (s_w.wdata !== d0 + 32'(b) || s_w.wlast !== (b == int'(len))) bad++;
         end
         @(negedge aclk);
      end
      m_wvalid = '0; s_wready = 1'b0;
      s_b = '{bid: 4'h1, bresp: 2'b00};
      s_bvalid = 1'b1; m_bready = '1;
      #1;
      bv = m_bvalid;
      if (s_awvalid !== 1'b0) leak++;
      if (s_bready !== 1'b1 || m_b !== s_b) bad++;
      @(negedge aclk);
      s_bvalid = 1'b0; m_bready = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      arst = 1'b1;
      m_awvalid = '1;
      @(negedge aclk); @(negedge aclk); #1;
      checks++;
      if (grant !== '0) begin failures++; $display("FAIL reset_grant: got %0h expected 0", grant); end
      checks++;
      if ({s_awvalid, s_wvalid, s_bready, err} !== 4'b0000) begin
         failures++; $display("FAIL reset_ctrl: got %b expected 0000", {s_awvalid, s_wvalid, s_bready, err});
      end
      checks++;
      if ({m_awready, m_wready, m_bvalid} !== 6'b0) begin
         failures++; $display("FAIL reset_mready: got %b expected 000000", {m_awready, m_wready, m_bvalid});
      end
      arst = 1'b0; m_awvalid = '0;
      @(negedge aclk);
   endtask

   task automatic test_single();
      logic [NUM_M-1:0] g, bv; int wc, beats, bad, leak; aw_t aw;
      do_reset();
      m_aw[0] = '{awid: 4'h1, awaddr: 32'h100, awlen: 4'd3, awsize: 3'd2, awburst: 2'b01};
      m_awvalid = 2'b01;
      serve(4'd3, -1, 32'hA0, g, wc, beats, bad, leak, bv, aw);
      checks++; if (wc !== 1) begin failures++; $display("FAIL single_latency: got %0d expected 1", wc); end
      checks++; if (g !== 2'b01) begin failures++; $display("FAIL single_grant: got %b expected 01", g); end
      checks++;
      if (aw.awaddr !== 32'h100 || aw.awlen !== 4'd3) begin
         failures++; $display("FAIL single_aw: got addr %0h len %0d expected addr 100 len 3", aw.awaddr, aw.awlen);
      end
      checks++; if (beats !== 4) begin failures++; $display("FAIL single_beats: got %0d expected 4", beats); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL single_data: got %0d errors expected 0", bad); end
      checks++; if (bv !== 2'b01) begin failures++; $display("FAIL single_bvalid: got %b expected 01", bv); end
      #1;
      checks++; if (grant !== '0) begin failures++; $display("FAIL single_idle: got %b expected 00", grant); end
   endtask

   task automatic test_contend();
      logic [NUM_M-1:0] g, bv; int wc, beats, bad, leak; aw_t aw;
      do_reset();
      m_aw[0] = '{awid: 4'h2, awaddr: 32'h200, awlen: 4'd1, awsize: 3'd2, awburst: 2'b01};
      m_aw[1] = '{awid: 4'h3, awaddr: 32'h300, awlen: 4'd1, awsize: 3'd2, awburst: 2'b01};
      m_awvalid = 2'b11;
      serve(4'd1, -1, 32'h10, g, wc, beats, bad, leak, bv, aw);
      checks++;
      if (g !== 2'b01 || aw.awaddr !== 32'h200) begin
         failures++; $display("FAIL contend_first: got grant %b addr %0h expected 01 200", g, aw.awaddr);
      end
      checks++; if (leak !== 0) begin failures++; $display("FAIL contend_leak: got %0d early AW expected 0", leak); end
      #1;
      checks++; if (grant !== '0) begin failures++; $display("FAIL contend_idle: got %b expected 00", grant); end
      serve(4'd1, -1, 32'h20, g, wc, beats, bad, leak, bv, aw);
      checks++;
      if (g !== 2'b10 || aw.awaddr !== 32'h300) begin
         failures++; $display("FAIL contend_second: got grant %b addr %0h expected 10 300", g, aw.awaddr);
      end
      checks++; if (wc !== 1) begin failures++; $display("FAIL back_to_back_gap: got %0d expected 1", wc); end
      checks++;
      if (beats !== 2 || bad !== 0 || bv !== 2'b10) begin
         failures++; $display("FAIL contend_txn: got beats %0d bad %0d bv %b expected 2 0 10", beats, bad, bv);
      end
   endtask

   task automatic test_alternate();
      logic [NUM_M-1:0] g, bv, exp_g; int wc, beats, bad, leak; aw_t aw;
      do_reset();
      for (int t = 0; t < 6; t++) begin
         m_awvalid = '1;
         exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
         serve(4'd0, -1, 32'h40, g, wc, beats, bad, leak, bv, aw);
         checks++;
         if (g !== exp_g || beats !== 1) begin
            failures++; $display("FAIL alternate_%0d: got grant %b beats %0d expected %b 1", t, g, beats, exp_g);
         end
      end
      m_awvalid = '0;
      @(negedge aclk);
   endtask

   task automatic test_wstall();
      logic [NUM_M-1:0] g, bv; int wc, beats, bad, leak; aw_t aw;
      do_reset();
      m_aw[0].awlen = 4'd1;
      m_awvalid = 2'b01;
      serve(4'd1, 1, 32'hD0, g, wc, beats, bad, leak, bv, aw);
      checks++; if (beats !== 2) begin failures++; $display("FAIL stall_beats: got %0d expected 2", beats); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL stall_ready: got %0d errors expected 0", bad); end
   endtask

   task automatic test_reset_mid();
      logic [NUM_M-1:0] g, bv; int wc, beats, bad, leak; aw_t aw;
      do_reset();
      m_aw[0].awlen = 4'd3;
      m_awvalid = 2'b01; s_awready = 1'b1;
      #1;
      for (int k = 0; k < 8 && s_awvalid !== 1'b1; k++) begin @(negedge aclk); #1; end
      checks++; if (s_awvalid !== 1'b1) begin failures++; $display("FAIL rstmid_aw: got 0 expected 1"); end
      @(negedge aclk);
      m_awvalid = '0; s_awready = 1'b0; m_wvalid = '1; s_wready = 1'b1;
      #1;
      checks++; if (s_wvalid !== 1'b1) begin failures++; $display("FAIL rstmid_data: got %b expected 1", s_wvalid); end
      arst = 1'b1;
      @(negedge aclk); #1;
      checks++;
      if ({grant, m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready, err} !== 12'b0) begin
         failures++;
         $display("FAIL rstmid_outputs: got %b expected 0",
                  {grant, m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready, err});
      end
      arst = 1'b0;
      clear_inputs();
      m_aw[1] = '{awid: 4'h4, awaddr: 32'h400, awlen: 4'd0, awsize: 3'd2, awburst: 2'b01};
      m_awvalid = 2'b10;
      serve(4'd0, -1, 32'hE0, g, wc, beats, bad, leak, bv, aw);
      checks++;
      if (g !== 2'b10 || wc !== 1 || beats !== 1 || bv !== 2'b10) begin
         failures++; $display("FAIL rstmid_regrant: got g %b wc %0d beats %0d bv %b expected 10 1 1 10", g, wc, beats, bv);
      end
   endtask

   task automatic test_len_check();
      logic [1:0] exp1;
      logic [2:0] exp2;
`ifdef AXI_WR_ARB_LEN_CHECK_EN
      exp1 = 2'b10;
      exp2 = 3'b111;
`else
      exp1 = 2'b01;
      exp2 = 3'b000;
`endif
      do_reset();
      m_aw[0].awlen = 4'd2;
      m_awvalid = 2'b01; s_awready = 1'b1;
      #1;
      for (int k = 0; k < 8 && s_awvalid !== 1'b1; k++) begin @(negedge aclk); #1; end
      checks++; if (s_awvalid !== 1'b1) begin failures++; $display("FAIL len_aw: got 0 expected 1"); end
      @(negedge aclk);
      m_awvalid = '0; s_awready = 1'b0; m_wvalid = 2'b01; s_wready = 1'b1;
      m_w[0].wdata = 32'hC0; m_w[0].wlast = 1'b0;
      #1;
      checks++;
      if ({err, s_w.wlast} !== 2'b00) begin failures++; $display("FAIL len_beat1: got %b expected 00", {err, s_w.wlast}); end
      @(negedge aclk);
      m_w[0].wdata = 32'hC1; m_w[0].wlast = 1'b1;
      #1;
      checks++;
      if ({err, s_w.wlast} !== exp1) begin failures++; $display("FAIL len_beat2: got %b expected %b", {err, s_w.wlast}, exp1); end
      @(negedge aclk);
      m_w[0].wdata = 32'hC2; m_w[0].wlast = 1'b0;
      #1;
      checks++;
      if ({err, s_w.wlast, m_wready[0]} !== exp2) begin
         failures++; $display("FAIL len_beat3: got %b expected %b", {err, s_w.wlast, m_wready[0]}, exp2);
      end
      @(negedge aclk);
      m_wvalid = '0; s_wready = 1'b0; s_bvalid = 1'b1; m_bready = 2'b01;
      #1;
      checks++; if (m_bvalid !== 2'b01) begin failures++; $display("FAIL len_resp: got %b expected 01", m_bvalid); end
      @(negedge aclk);
      s_bvalid = 1'b0; m_bready = '0;
      #1;
      checks++; if (grant !== '0) begin failures++; $display("FAIL len_idle: got %b expected 00", grant); end
   endtask

   initial begin
      clear_inputs();
      arst = 1'b1;
      test_reset();
      test_single();
      test_contend();
      test_alternate();
      test_wstall();
      test_reset_mid();
      test_len_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
